// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants and priority helper for the key conditioner
package key_pkg;

    localparam int KEY_IDX_RESET           = 2;
    localparam int KEY_IDX_CLEAR           = 1;
    localparam int KEY_IDX_ENTER           = 0;
    localparam int MAX_DIGIT               = 9;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    // Keeps only the highest-priority event: reset > clear > enter.
    function automatic logic [2:0] resolve_priority(input logic [2:0] ev);
        logic [2:0] r;
        r = 3'b000;
        if (ev[KEY_IDX_RESET]) begin
            r[KEY_IDX_RESET] = 1'b1;
        end else if (ev[KEY_IDX_CLEAR]) begin
            r[KEY_IDX_CLEAR] = 1'b1;
        end else if (ev[KEY_IDX_ENTER]) begin
            r[KEY_IDX_ENTER] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key: 2-FF synchroniser, stability counter, debounced level
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Released (1) is the safe reset state for an active-low button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced, priority-resolved key pulses and digit capture
// Optional auto-repeat is enabled by defining KEY_AUTOREPEAT_EN.
module key_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [2:0] KEY,
    input  logic [3:0] SW,
    output logic [2:0] KEY_LEVEL,
    output logic [2:0] KEY_PRESS,
    output logic [3:0] DIGIT,
    output logic       DIGIT_VALID,
    output logic       DIGIT_ERR
);

    logic [2:0] level;
    logic [2:0] level_d;
    logic [2:0] fall;
    logic [2:0] events;
    logic [2:0] accepted;
    logic [3:0] sw_sync1;
    logic [3:0] sw_sync2;

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (CLOCK_50),
            .rst_n(RESET_N),
            .raw  (KEY[i]),
            .level(level[i])
        );
    end

    assign KEY_LEVEL = level;
    assign fall      = level_d & ~level;

`ifdef KEY_AUTOREPEAT_EN
    logic [2:0] rep_fire;

    // cnt restarts at 1 on each emitted event so the next fire lands exactly
    // DELAY (first) or PERIOD (later) cycles after that event's pulse.
    for (genvar i = 0; i < 3; i++) begin : g_rep
        logic [31:0] cnt;
        logic        first;

        assign rep_fire[i] = !level[i] && !fall[i] &&
                             (cnt == (first ? 32'(REPEAT_DELAY) : 32'(REPEAT_PERIOD)));

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                cnt   <= '0;
                first <= 1'b1;
            end else if (level[i]) begin
                cnt   <= '0;
                first <= 1'b1;
            end else if (fall[i]) begin
                cnt   <= 32'd1;
                first <= 1'b1;
            end else if (rep_fire[i]) begin
                cnt   <= 32'd1;
                first <= 1'b0;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

    assign events = fall | rep_fire;
`else
    assign events = fall;
`endif

    assign accepted = resolve_priority(events);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sw_sync1    <= 4'd0;
            sw_sync2    <= 4'd0;
            level_d     <= 3'b111;
            KEY_PRESS   <= 3'b000;
            DIGIT       <= 4'd0;
            DIGIT_VALID <= 1'b0;
            DIGIT_ERR   <= 1'b0;
        end else begin
            sw_sync1    <= SW;
            sw_sync2    <= sw_sync1;
            level_d     <= level;
            KEY_PRESS   <= accepted;
            DIGIT_VALID <= accepted[KEY_IDX_ENTER];
            if (accepted[KEY_IDX_ENTER]) begin
                DIGIT     <= sw_sync2;
                DIGIT_ERR <= (sw_sync2 > 4'(MAX_DIGIT));
            end else if (accepted[KEY_IDX_CLEAR]) begin
                DIGIT_ERR <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner with DEBOUNCE_CYCLES=4
module tb_key_conditioner;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic       CLOCK_50;
    logic       RESET_N;
    logic [2:0] KEY;
    logic [3:0] SW;
    logic [2:0] KEY_LEVEL;
    logic [2:0] KEY_PRESS;
    logic [3:0] DIGIT;
    logic       DIGIT_VALID;
    logic       DIGIT_ERR;

    typedef struct {
        logic [2:0] press;
        logic       valid;
        logic [3:0] digit;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [3:0] m_digit = 4'd0;
    logic       m_err   = 1'b0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DB)
`ifdef KEY_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
`endif
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .KEY        (KEY),
        .SW         (SW),
        .KEY_LEVEL  (KEY_LEVEL),
        .KEY_PRESS  (KEY_PRESS),
        .DIGIT      (DIGIT),
        .DIGIT_VALID(DIGIT_VALID),
        .DIGIT_ERR  (DIGIT_ERR)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (KEY_PRESS !== 3'b000 || DIGIT_VALID !== 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: got press=%b valid=%b at cycle %0d, required no pulse",
                         KEY_PRESS, DIGIT_VALID, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (KEY_PRESS !== mon_e.press || DIGIT_VALID !== mon_e.valid ||
                    DIGIT !== mon_e.digit || DIGIT_ERR !== mon_e.err || cyc != mon_e.cyc) begin
                    n_err++;
                    $display("FAIL event: got press=%b valid=%b digit=%0d err=%b cyc=%0d, required press=%b valid=%b digit=%0d err=%b cyc=%0d",
                             KEY_PRESS, DIGIT_VALID, DIGIT, DIGIT_ERR, cyc,
                             mon_e.press, mon_e.valid, mon_e.digit, mon_e.err, mon_e.cyc);
                end
            end
        end
    end

    // Drives one press (mask of keys falling together) and queues every pulse it must cause.
    task automatic press_key(input logic [2:0] mask, input logic [3:0] sw, input int hold);
        exp_t       e;
        logic [2:0] win;
        int         n0;
        SW = sw;
        @(negedge CLOCK_50);
        KEY = KEY & ~mask;
        n0  = cyc;
        win = mask[2] ? 3'b100 : (mask[1] ? 3'b010 : 3'b001);
        if (win[0]) begin
            m_digit = sw;
            m_err   = (sw > 4'd9);
        end else if (win[1]) begin
            m_err = 1'b0;
        end
        e.press = win;
        e.valid = win[0];
        e.digit = m_digit;
        e.err   = m_err;
        e.cyc   = n0 + LAT;
        exp_q.push_back(e);
`ifdef KEY_AUTOREPEAT_EN
        for (int f = n0 + LAT + RD; f <= n0 + hold + DB + 2; f += RP) begin
            e.cyc = f;
            exp_q.push_back(e);
        end
`endif
        repeat (hold) @(negedge CLOCK_50);
        KEY = KEY | mask;
        repeat (12) @(negedge CLOCK_50);
    endtask

    task automatic test_reset;
        RESET_N = 1'b0;
        KEY     = 3'b000;
        SW      = 4'd0;
        repeat (4) @(negedge CLOCK_50);
        n_cmp++;
        if (KEY_LEVEL !== 3'b111) begin
            n_err++;
            $display("FAIL reset_level: got %b, required 111", KEY_LEVEL);
        end
        n_cmp++;
        if (KEY_PRESS !== 3'b000) begin
            n_err++;
            $display("FAIL reset_press: got %b, required 000", KEY_PRESS);
        end
        n_cmp++;
        if (DIGIT !== 4'd0) begin
            n_err++;
            $display("FAIL reset_digit: got %0d, required 0", DIGIT);
        end
        n_cmp++;
        if (DIGIT_ERR !== 1'b0 || DIGIT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got err=%b valid=%b, required 0 0", DIGIT_ERR, DIGIT_VALID);
        end
        KEY = 3'b111;
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (10) @(negedge CLOCK_50);
    endtask

    task automatic test_enter;
        press_key(3'b001, 4'd7, 20);
        n_cmp++;
        if (DIGIT !== 4'd7 || DIGIT_ERR !== 1'b0) begin
            n_err++;
            $display("FAIL enter_hold: got digit=%0d err=%b, required 7 0", DIGIT, DIGIT_ERR);
        end
    endtask

    task automatic test_bounce;
        for (int i = 0; i < 12; i++) begin
            KEY[0] = ((i / 2) % 2 == 1);
            @(negedge CLOCK_50);
            n_cmp++;
            if (KEY_LEVEL[0] !== 1'b1) begin
                n_err++;
                $display("FAIL bounce_level: got %b at step %0d, required 1", KEY_LEVEL[0], i);
            end
        end
        KEY[0] = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        n_cmp++;
        if (KEY_LEVEL !== 3'b111) begin
            n_err++;
            $display("FAIL bounce_settle: got %b, required 111", KEY_LEVEL);
        end
    endtask

    task automatic test_simultaneous;
        press_key(3'b101, 4'd3, 20);
        n_cmp++;
        if (DIGIT !== 4'd7) begin
            n_err++;
            $display("FAIL simul_digit: got %0d, required 7", DIGIT);
        end
    endtask

    task automatic test_invalid_digit;
        press_key(3'b001, 4'd12, 20);
        n_cmp++;
        if (DIGIT !== 4'd12 || DIGIT_ERR !== 1'b1) begin
            n_err++;
            $display("FAIL invalid_capture: got digit=%0d err=%b, required 12 1", DIGIT, DIGIT_ERR);
        end
        press_key(3'b010, 4'd1, 20);
        n_cmp++;
        if (DIGIT !== 4'd12 || DIGIT_ERR !== 1'b0) begin
            n_err++;
            $display("FAIL clear_err: got digit=%0d err=%b, required 12 0", DIGIT, DIGIT_ERR);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] vals [3];
        vals[0] = 4'd9;
        vals[1] = 4'd10;
        vals[2] = 4'd0;
        for (int i = 0; i < 3; i++) begin
            press_key(3'b001, vals[i], 8);
            n_cmp++;
            if (DIGIT !== vals[i] || DIGIT_ERR !== (vals[i] > 4'd9)) begin
                n_err++;
                $display("FAIL b2b_digit: got digit=%0d err=%b, required %0d %b",
                         DIGIT, DIGIT_ERR, vals[i], (vals[i] > 4'd9));
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        SW = 4'd5;
        @(negedge CLOCK_50);
        KEY[0] = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        RESET_N = 1'b0;
        m_digit = 4'd0;
        m_err   = 1'b0;
        @(negedge CLOCK_50);
        n_cmp++;
        if (KEY_LEVEL !== 3'b111 || KEY_PRESS !== 3'b000 || DIGIT !== 4'd0) begin
            n_err++;
            $display("FAIL mid_reset: got level=%b press=%b digit=%0d, required 111 000 0",
                     KEY_LEVEL, KEY_PRESS, DIGIT);
        end
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        m_digit = 4'd5;
        e.press = 3'b001;
        e.valid = 1'b1;
        e.digit = 4'd5;
        e.err   = 1'b0;
        e.cyc   = cyc + LAT;
        exp_q.push_back(e);
        repeat (8) @(negedge CLOCK_50);
        KEY[0] = 1'b1;
        repeat (12) @(negedge CLOCK_50);
    endtask

`ifdef KEY_AUTOREPEAT_EN
    task automatic test_autorepeat;
        press_key(3'b010, 4'd2, 29);
        repeat (20) @(negedge CLOCK_50);
    endtask
`endif

    initial begin
        test_reset();
        test_enter();
        test_bounce();
        test_simultaneous();
        test_invalid_digit();
        test_back_to_back();
        test_reset_mid();
`ifdef KEY_AUTOREPEAT_EN
        test_autorepeat();
`endif
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge CLOCK_50);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pulses still missing, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
